tap_route: RTL and testbench



---
 rtl/tap_pkg.sv | 27 ++
 rtl/tap_route.sv | 54 +++++
 tb/tb_tap_route.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// Shared TAP controller definitions: fixed 4-bit state encoding and reset state.
package tap_pkg;

  localparam int unsigned TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PAUDR = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDDR = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PAUIR = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPDIR = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_t;

  localparam tap_state_t TAP_RESET_STATE = TAP_TLR;

endpackage

// File: rtl/tap_route.sv
// IEEE 1149.1 TAP controller; the state register drives the observation pins directly.
module tap_route
  import tap_pkg::*;
(
  input  logic GCLK_Pad,
  input  logic TRST_Pad,
  input  logic TMS_Pad,
  output logic state_obs0_Pad,
  output logic state_obs1_Pad,
  output logic state_obs2_Pad,
  output logic state_obs3_Pad
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      state_q <= TAP_RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Standard TAP next-state arcs; the IR column mirrors the DR column.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:   state_d = TMS_Pad ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   state_d = TMS_Pad ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: state_d = TMS_Pad ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: state_d = TMS_Pad ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  state_d = TMS_Pad ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: state_d = TMS_Pad ? TAP_UPDDR : TAP_PAUDR;
      TAP_PAUDR: state_d = TMS_Pad ? TAP_EX2DR : TAP_PAUDR;
      TAP_EX2DR: state_d = TMS_Pad ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: state_d = TMS_Pad ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: state_d = TMS_Pad ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: state_d = TMS_Pad ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  state_d = TMS_Pad ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: state_d = TMS_Pad ? TAP_UPDIR : TAP_PAUIR;
      TAP_PAUIR: state_d = TMS_Pad ? TAP_EX2IR : TAP_PAUIR;
      TAP_EX2IR: state_d = TMS_Pad ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR: state_d = TMS_Pad ? TAP_SELDR : TAP_RTI;
      default:   state_d = TAP_RESET_STATE;
    endcase
  end

  assign state_obs0_Pad = state_q[0];
  assign state_obs1_Pad = state_q[1];
  assign state_obs2_Pad = state_q[2];
  assign state_obs3_Pad = state_q[3];

endmodule

// File: tb/tb_tap_route.sv
// Bench for tap_route: table-driven TAP model, directed scans, async reset cases, random TMS.
module tb_tap_route;

  logic clk;
  logic trst;
  logic tms;
  logic o0, o1, o2, o3;
  logic [3:0] obs;
  logic [3:0] exp_st;
  logic chk_en;

  int checks;
  int errors;

  int nxt0 [16];
  int nxt1 [16];
  bit cov  [16][2];

  tap_route dut (
    .GCLK_Pad       (clk),
    .TRST_Pad       (trst),
    .TMS_Pad        (tms),
    .state_obs0_Pad (o0),
    .state_obs1_Pad (o1),
    .state_obs2_Pad (o2),
    .state_obs3_Pad (o3)
  );

  assign obs = {o3, o2, o1, o0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive TMS for one edge, then advance the model after the edge.
  task automatic tick(input logic t);
    tms = t;
    @(posedge clk);
    #1;
    cov[exp_st][t] = 1'b1;
    exp_st = t ? 4'(nxt1[exp_st]) : 4'(nxt0[exp_st]);
  endtask

  task automatic async_reset_pulse(input string nm);
    trst = 1'b1;
    #1;
    exp_st = 4'hF;
    check(nm, obs, 4'hF);
    trst = 1'b0;
    #1;
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) check("edge", obs, exp_st);
  end

  initial begin
    int dr_t [9];
    int dr_c [9];
    int ir_t [7];
    int ir_c [7];
    int esc_c [6];
    int cov_n;

    // Next-state tables indexed by state code, from the standard TAP diagram.
    nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    dr_t  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
    dr_c  = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'hC};
    ir_t  = '{1, 1, 0, 0, 1, 1, 0};
    ir_c  = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hD, 4'hC};
    esc_c = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF, 4'hF};

    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    tms    = 1'b0;
    trst   = 1'b1;
    exp_st = 4'hF;
    #1;
    check("reset_no_clk", obs, 4'hF);
    #1;
    trst = 1'b0;
    #1;
    chk_en = 1'b1;

    tick(1'b0);
    check("reset_to_rti", obs, 4'hC);

    for (int i = 0; i < 9; i++) begin
      tick(dr_t[i][0]);
      check("dr_scan", obs, 4'(dr_c[i]));
    end

    for (int i = 0; i < 7; i++) begin
      tick(ir_t[i][0]);
      check("ir_scan", obs, 4'(ir_c[i]));
    end

    tick(1'b1); tick(1'b0); tick(1'b0);
    check("enter_shdr", obs, 4'h2);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      check("escape", obs, 4'(esc_c[i]));
    end

    tick(1'b0);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
    check("enter_shir", obs, 4'hA);
    async_reset_pulse("mid_scan_reset");
    tick(1'b0);
    check("after_reset_rti", obs, 4'hC);

    // Reset held across edges ignores the clock.
    trst   = 1'b1;
    exp_st = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tms = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold", obs, 4'hF);
    end
    trst = 1'b0;
    #1;
    tick(1'b0);
    check("hold_release", obs, 4'hC);

    // Reset rising together with a clock edge wins.
    tms = 1'b1;
    @(posedge clk);
    trst   = 1'b1;
    exp_st = 4'hF;
    #1;
    check("reset_vs_edge", obs, 4'hF);
    trst = 1'b0;
    #1;

    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) async_reset_pulse("rand_reset");
    end

    cov_n = 0;
    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 2; t++)
        if (cov[s][t]) cov_n++;
    checks++;
    if (cov_n != 32) begin
      errors++;
      $display("FAIL arc_cov: got %0d expected 32", cov_n);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
